// File: rtl/bcd_display_scan.sv
//==============================================================================
// Module   : bcd_display_scan
// Purpose  : Two-digit multiplexed seven-segment driver. Captures a BCD pair
//            on a load strobe into a shadow register and commits it to the
//            display only at a frame boundary, so a frame never shows a mix of
//            old and new digits. Scans units then tens, blanking every digit
//            enable during the first cycle of each slot. Optionally suppresses
//            a leading zero in the tens digit, and flags non-BCD digits.
// Ports    : clk          - clock, rising edge
//            rst_         - asynchronous active-low reset
//            bcd0, bcd1   - units / tens digit to capture
//            load         - single-cycle capture strobe
//            seg[6:0]     - segments {g,f,e,d,c,b,a}
//            an[1:0]      - digit enables, an[0] = units, an[1] = tens
//            err          - a committed digit is above 9 (always active-high)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_display_scan #(
  parameter int REFRESH_DIV = 1000,
  parameter bit BLANK_LZ    = 1'b1,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic       load,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int             CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]     SEG_ZERO = 7'h3F;
  localparam logic [6:0]     SEG_RST  = ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;
  localparam logic [1:0]     AN_OFF   = ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dig_q, dig_d;
  logic [7:0]       shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic [7:0]       disp_q, disp_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             err_q, err_d;

  logic             wrap;
  logic             frame_end;
  logic [3:0]       cur_digit;
  logic [6:0]       seg_raw;
  logic [1:0]       an_raw;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h40;  // non-BCD code: dash
    endcase
    return p;
  endfunction

  // Next state of prescaler, slot, shadow and committed pair.
  always_comb begin
    wrap      = (cnt_q == CNT_MAX);
    frame_end = wrap && dig_q;

    cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
    dig_d    = wrap ? ~dig_q : dig_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    disp_d   = disp_q;

    if (load) begin
      shadow_d = {bcd1, bcd0};
      if (frame_end) begin
        // Load coinciding with the boundary bypasses the shadow wait.
        disp_d = {bcd1, bcd0};
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (frame_end && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end
  end

  // Outputs are derived from next-state values so the registered outputs
  // line up with cnt/dig/disp on the same edge.
  always_comb begin
    cur_digit = dig_d ? disp_d[7:4] : disp_d[3:0];
    seg_raw   = decode(cur_digit);
    an_raw    = 2'b00;
    if (cnt_d != '0) begin
      if (!dig_d)
        an_raw = 2'b01;
      else if (!(BLANK_LZ && (disp_d[7:4] == 4'd0)))
        an_raw = 2'b10;
    end
    seg_d = ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_d  = ACTIVE_LOW ? ~an_raw  : an_raw;
    err_d = (disp_d[7:4] > 4'd9) || (disp_d[3:0] > 4'd9);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q    <= '0;
      dig_q    <= 1'b0;
      shadow_q <= 8'h00;
      pend_q   <= 1'b0;
      disp_q   <= 8'h00;
      seg_q    <= SEG_RST;
      an_q     <= AN_OFF;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      disp_q   <= disp_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      err_q    <= err_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
//==============================================================================
// Module   : tb_bcd_display_scan
// Purpose  : Directed bench for bcd_display_scan with REFRESH_DIV = 4. Three
//            instances share the stimulus: default (leading-zero blank,
//            active-low), no leading-zero blank, and active-high outputs.
//            p tracks the frame position: 0..3 units slot, 4..7 tens slot.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bcd_display_scan;

  logic       clk = 1'b0;
  logic       rst_;
  logic [3:0] bcd0, bcd1;
  logic       load;

  logic [6:0] seg1, seg2, seg3;
  logic [1:0] an1, an2, an3;
  logic       err1, err2, err3;

  int n_chk  = 0;
  int n_fail = 0;
  int p      = 0;

  always #5 clk = ~clk;

  bcd_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .rst_(rst_), .bcd0(bcd0), .bcd1(bcd1), .load(load),
    .seg(seg1), .an(an1), .err(err1)
  );

  bcd_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1)) u_nlz (
    .clk(clk), .rst_(rst_), .bcd0(bcd0), .bcd1(bcd1), .load(load),
    .seg(seg2), .an(an2), .err(err2)
  );

  bcd_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b0)) u_ah (
    .clk(clk), .rst_(rst_), .bcd0(bcd0), .bcd1(bcd1), .load(load),
    .seg(seg3), .an(an3), .err(err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    p = (p + 1) % 8;
  endtask

  task automatic run_to(input int t);
    for (int i = 0; i < 8 && p != t; i++) tick();
  endtask

  task automatic chk(input string tag,
                     input logic [6:0] os, input logic [1:0] oa, input logic oe,
                     input logic [6:0] es, input logic [1:0] ea, input logic ee);
    n_chk++;
    assert (os === es) else begin
      n_fail++;
      $error("FAIL %s seg: observed %b expected %b", tag, os, es);
    end
    n_chk++;
    assert (oa === ea) else begin
      n_fail++;
      $error("FAIL %s an: observed %b expected %b", tag, oa, ea);
    end
    n_chk++;
    assert (oe === ee) else begin
      n_fail++;
      $error("FAIL %s err: observed %b expected %b", tag, oe, ee);
    end
  endtask

  initial begin
    rst_ = 1'b0;
    load = 1'b0;
    bcd0 = 4'h0;
    bcd1 = 4'h0;
    tick();
    tick();
    p = 0;
    chk("reset",    seg1, an1, err1, 7'h40, 2'b11, 1'b0);
    chk("reset_ah", seg3, an3, err3, 7'h3F, 2'b00, 1'b0);

    // Frame with disp = 00: units slot shows 0, tens slot fully blanked.
    rst_ = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("f0", seg1, an1, err1, 7'h40, (p >= 1 && p <= 3) ? 2'b10 : 2'b11, 1'b0);
      if (p == 1) chk("f0_ah",  seg3, an3, err3, 7'h3F, 2'b01, 1'b0);
      if (p == 5) chk("f0_nlz", seg2, an2, err2, 7'h40, 2'b01, 1'b0);
    end

    // Load 42 mid units slot; must wait for the next boundary.
    tick();                      // p = 0
    tick();                      // p = 1
    bcd1 = 4'h4; bcd0 = 4'h2; load = 1'b1;
    tick();                      // p = 2
    load = 1'b0;
    chk("pre_commit",      seg1, an1, err1, 7'h40, 2'b10, 1'b0);
    run_to(5);
    chk("pre_commit_tens", seg1, an1, err1, 7'h40, 2'b11, 1'b0);
    run_to(0);
    chk("commit42_blank",  seg1, an1, err1, 7'h24, 2'b11, 1'b0);
    tick();                      // p = 1
    chk("units2",          seg1, an1, err1, 7'h24, 2'b10, 1'b0);
    chk("units2_ah",       seg3, an3, err3, 7'h5B, 2'b01, 1'b0);
    run_to(4);
    chk("tens4_blank",     seg1, an1, err1, 7'h19, 2'b11, 1'b0);
    tick();                      // p = 5
    chk("tens4",           seg1, an1, err1, 7'h19, 2'b01, 1'b0);
    chk("tens4_ah",        seg3, an3, err3, 7'h66, 2'b10, 1'b0);
    run_to(7);

    // Three loads in one frame; only the last (58) may ever appear.
    tick();                      // p = 0
    bcd1 = 4'h0; bcd0 = 4'h7; load = 1'b1;
    tick();                      // p = 1
    bcd1 = 4'h3; bcd0 = 4'h3;
    tick();                      // p = 2
    bcd1 = 4'h5; bcd0 = 4'h8;
    tick();                      // p = 3
    load = 1'b0;
    chk("multi_units", seg1, an1, err1, 7'h24, 2'b10, 1'b0);
    for (int k = 4; k < 8; k++) begin
      tick();
      chk("multi_tens", seg1, an1, err1, 7'h19, (p == 4) ? 2'b11 : 2'b01, 1'b0);
    end
    tick();                      // p = 0
    chk("commit58",    seg1, an1, err1, 7'h00, 2'b11, 1'b0);
    tick();                      // p = 1
    chk("units8",      seg1, an1, err1, 7'h00, 2'b10, 1'b0);
    run_to(5);
    chk("tens5",       seg1, an1, err1, 7'h12, 2'b01, 1'b0);

    // Load 9A exactly at the boundary cycle: committed on that edge.
    run_to(7);
    chk("pre_9a",      seg1, an1, err1, 7'h12, 2'b01, 1'b0);
    bcd1 = 4'h9; bcd0 = 4'hA; load = 1'b1;
    tick();                      // p = 0
    load = 1'b0;
    chk("commit9a",    seg1, an1, err1, 7'h3F, 2'b11, 1'b1);
    tick();                      // p = 1
    chk("dash",        seg1, an1, err1, 7'h3F, 2'b10, 1'b1);
    chk("dash_ah",     seg3, an3, err3, 7'h40, 2'b01, 1'b1);
    run_to(5);
    chk("tens9",       seg1, an1, err1, 7'h10, 2'b01, 1'b1);

    // Load 05: err holds until the valid pair commits; tens blank vs shown.
    bcd1 = 4'h0; bcd0 = 4'h5; load = 1'b1;
    tick();                      // p = 6
    load = 1'b0;
    chk("pend05",      seg1, an1, err1, 7'h10, 2'b01, 1'b1);
    run_to(0);
    chk("commit05",    seg1, an1, err1, 7'h12, 2'b11, 1'b0);
    run_to(5);
    chk("lz_blank",    seg1, an1, err1, 7'h40, 2'b11, 1'b0);
    chk("lz_shown",    seg2, an2, err2, 7'h40, 2'b01, 1'b0);

    // Reset mid tens slot with a pending 77; load during reset is ignored.
    bcd1 = 4'h7; bcd0 = 4'h7; load = 1'b1;
    tick();                      // p = 6, pend set
    load = 1'b0;
    #2;
    rst_ = 1'b0;
    #1;
    chk("rst_async",   seg1, an1, err1, 7'h40, 2'b11, 1'b0);
    bcd1 = 4'h8; bcd0 = 4'h8; load = 1'b1;
    tick();
    tick();
    load = 1'b0;
    rst_ = 1'b1;
    p = 0;
    tick();                      // p = 1
    chk("rel_units",   seg1, an1, err1, 7'h40, 2'b10, 1'b0);
    run_to(0);
    chk("rel_frame",   seg1, an1, err1, 7'h40, 2'b11, 1'b0);
    tick();                      // p = 1
    chk("rel_no_pend", seg1, an1, err1, 7'h40, 2'b10, 1'b0);
    run_to(5);
    chk("rel_tens",    seg1, an1, err1, 7'h40, 2'b11, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_display_scan.md
# bcd_display_scan

Two-digit multiplexed seven-segment display driver and the consumer of the two-digit BCD counter's `bcd1`/`bcd0` outputs. It captures a BCD pair on a load strobe and holds it in a shadow register. The pair is committed to the display only at a frame boundary, so the displayed value never tears mid-frame. The block time-multiplexes the two digits onto one segment bus, with inter-digit blanking, leading-zero suppression and invalid-code flagging.

## Interface
- `REFRESH_DIV`, default 1000: clock cycles per digit slot; minimum 2.
- `BLANK_LZ`, default 1: when 1, tens digit is blanked if its value is 0.
- `ACTIVE_LOW`, default 1: when 1, `seg` and `an` are active-low; when 0, active-high.
- `clk`, input, 1: sole clock, rising edge.
- `rst_`, input, 1: reset, asynchronous and active-low.
- `bcd0`, input, 4: units digit to capture.
- `bcd1`, input, 4: tens digit to capture.
- `load`, input, 1: single-cycle capture strobe; sampled every cycle.
- `seg`, output, 7: segments {g,f,e,d,c,b,a}, bit 0 = a.
- `an`, output, 2: digit enables; an[0] = units, an[1] = tens.
- `err`, output, 1: high while either committed digit is greater than 9.

## Operation
- **Registers**
  - `shadow`: 8 bits, plus a `pend` flag.
  - `disp`: 8 bits, the committed pair.
  - `cnt`: prescaler, 0..REFRESH_DIV-1, width clog2(REFRESH_DIV).
  - `dig`: 0 = units slot, 1 = tens slot.
- **Prescaler and slot**
  - `cnt` increments every cycle and wraps at REFRESH_DIV-1 to 0.
  - On the wrap, `dig` toggles.
- **Frame boundary**: the cycle in which `cnt` wraps while `dig` = 1, i.e. tens slot → units slot.
- **Capture**: `load` = 1 → `shadow` <= {bcd1,bcd0} and `pend` <= 1.
- **Commit**: at a frame boundary with `pend` = 1 → `disp` <= `shadow` and `pend` <= 0.
- **load at a frame boundary**
  - {bcd1,bcd0} is written directly to `disp`.
  - `shadow` is also updated.
  - `pend` <= 0.
- **Multiple loads before a boundary**: the last load wins.
- **Decode per digit**
  - 0–9: standard patterns. Active-high values: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, {g..a}).
  - 10–15: dash, g only (40 active-high).
- **Blanking**
  - While `cnt` == 0, both `an` lines are inactive (anti-ghost cycle); `seg` carries the new slot's pattern.
  - With BLANK_LZ = 1 and tens = 0, an[1] stays inactive for the whole tens slot.
  - The units digit is never suppressed.
- **`err`**: disp[7:4] > 9 or disp[3:0] > 9; updates with `disp`.
- **Polarity**: with ACTIVE_LOW = 1, `seg` and `an` are bitwise inverted; `err` is always active-high.

## Timing
- `seg`, `an` and `err` are registers. They are updated on the same edge as `cnt`/`dig`/`disp` and always reflect the current register values (no extra pipeline skew).
- **Reset values** (async, immediate):
  - `cnt` = 0, `dig` = 0, `shadow` = 0, `disp` = 0, `pend` = 0, `err` = 0.
  - `an` is inactive (2'b11 with ACTIVE_LOW).
  - `seg` shows "0": 7'b1000000 with ACTIVE_LOW.
- **Load to display latency**: 1 cycle (load at a boundary) to 2×REFRESH_DIV cycles (load just after a boundary).
- **Slot length**: exactly REFRESH_DIV cycles; 1 blank cycle, then REFRESH_DIV-1 active cycles.
- **Reset asserted mid-frame**: all state returns to reset values immediately and any pending capture is discarded. The first units slot begins on the first edge after release.
- **`load` during reset**: ignored.

## Test plan
- **Reset**, REFRESH_DIV=4, ACTIVE_LOW=1, no load: `an` is 11 at cnt=0, then 10 for 3 cycles; `seg` = 1000000; the tens slot keeps `an` = 11 throughout (BLANK_LZ); `err` = 0.
- **Load 4'h4/4'h2** (tens=4, units=2) mid units slot: `disp` unchanged until the next tens→units wrap. Then the units slot shows `seg` = ~5B, and the tens slot shows `seg` = ~66 with an = 01 for cycles 1–3.
- **Three loads in one frame** (07, 33, 58): only 58 is committed at the boundary; the intermediate values never appear on `seg`.
- **Load 0x9A at the exact boundary cycle**: committed the same edge. Units shows a dash (~40), tens shows ~6F, and `err` = 1 until a valid load commits.
- **BLANK_LZ=0, load 05**: the tens slot drives an = 01 with `seg` = ~3F.
- **rst_ pulled low mid tens slot with `pend` = 1**: outputs return to reset values immediately. After release the pending value is never shown, and units shows "0".
